mem_access_stage: RTL and testbench

Parametrised memory-stage engine that sits between execute and write-back and owns the data-memory bus. It accepts one instruction per handshake and runs a registered request/acknowledge transaction to memory, with a wait-cycle timeout. It returns load data, or a no-write token, to write-back in program order. It keeps the pipeline's global branch-reference bit and squashes wrong-path instructions before they touch memory.

---
 rtl/mem_access_stage.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage between execute and write-back. Owns the data bus,
// runs one request/ack transaction at a time with a wait-cycle timeout, and hands
// tokens to write-back in program order. Wrong-path instructions are squashed at accept.
// Optional feature macro: MEM_ACCESS_BYTE_EN enables sub-word lanes, store replication,
// load extraction and alignment checking. Without it every access is full width.
module mem_access_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr_in,
  input  logic                branch_in,
  input  logic                branch_ref,
  output logic                branch_ref_global,
  input  logic                is_load,
  input  logic                is_store,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [3:0]          rd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   alu_in,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_rd,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_w_en,
  output logic [31:0]         out_instr,
  output logic                bus_err
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned LaneW    = $clog2(NumBytes);
  localparam int unsigned CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          HasTmo   = (TIMEOUT != 0);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic                bref_q, bref_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NumBytes-1:0] mem_be_q, mem_be_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          pend_rd_q, pend_rd_d;
  logic [31:0]         pend_instr_q, pend_instr_d;
  logic                pend_tag_q, pend_tag_d;
  logic                pend_load_q, pend_load_d;
  logic [1:0]          pend_size_q, pend_size_d;
  logic                pend_sext_q, pend_sext_d;
  logic [LaneW-1:0]    pend_lane_q, pend_lane_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          out_rd_q, out_rd_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_w_en_q, out_w_en_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic                bus_err_q, bus_err_d;

  logic                accept;
  logic                timeout_hit;
  logic [LaneW-1:0]    lane_c;
  logic [NumBytes-1:0] be_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                misaligned_c;
  logic [DATA_W-1:0]   load_data_c;

  assign in_ready    = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign timeout_hit = HasTmo && (cnt_q == CntW'(TIMEOUT - 1));
  assign lane_c      = addr[LaneW-1:0];

`ifdef MEM_ACCESS_BYTE_EN
  logic [DATA_W-1:0] shifted_c;

  // Lane steering and alignment for the instruction being accepted.
  always_comb begin
    be_c         = '1;
    wdata_c      = wdata;
    misaligned_c = ((size == 2'b01) && lane_c[0]) || (size[1] && (lane_c != '0));
    if (size == 2'b00) begin
      be_c = NumBytes'(1) << lane_c;
    end else if (size == 2'b01) begin
      be_c = NumBytes'(3) << lane_c;
    end
    for (int i = 0; i < int'(NumBytes); i++) begin
      case (size)
        2'b00:   wdata_c[8*i +: 8] = wdata[7:0];
        2'b01:   wdata_c[8*i +: 8] = wdata[8*(i%2) +: 8];
        default: wdata_c[8*i +: 8] = wdata[8*i +: 8];
      endcase
    end
  end

  // Shift the addressed lane down and extend sub-word loads.
  always_comb begin
    shifted_c   = mem_rdata >> {pend_lane_q, 3'b000};
    load_data_c = shifted_c;
    if (pend_size_q == 2'b00) begin
      for (int i = 8; i < int'(DATA_W); i++) load_data_c[i] = pend_sext_q & shifted_c[7];
    end else if (pend_size_q == 2'b01) begin
      for (int i = 16; i < int'(DATA_W); i++) load_data_c[i] = pend_sext_q & shifted_c[15];
    end
  end
`else
  logic unused_cfg;

  assign be_c         = '1;
  assign wdata_c      = wdata;
  assign misaligned_c = 1'b0;
  assign load_data_c  = mem_rdata;
  assign unused_cfg   = ^{pend_size_q, pend_sext_q, pend_lane_q};
`endif

  // Next-state: accept/squash in idle, ack or timeout while a request is pending.
  always_comb begin
    state_d      = state_q;
    bref_d       = branch_ref;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    cnt_d        = cnt_q;
    pend_rd_d    = pend_rd_q;
    pend_instr_d = pend_instr_q;
    pend_tag_d   = pend_tag_q;
    pend_load_d  = pend_load_q;
    pend_size_d  = pend_size_q;
    pend_sext_d  = pend_sext_q;
    pend_lane_d  = pend_lane_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_rd_d     = out_rd_q;
    out_data_d   = out_data_q;
    out_w_en_d   = out_w_en_q;
    out_instr_d  = out_instr_q;
    bus_err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // A tag that disagrees with the reference is wrong-path: drop it silently.
        if (accept && (branch_in == bref_q)) begin
          out_rd_d    = rd;
          out_instr_d = instr_in;
          if (!is_load && !is_store) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_in;
            out_w_en_d  = 1'b1;
          end else if (misaligned_c) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_w_en_d  = 1'b0;
            bus_err_d   = 1'b1;
          end else begin
            state_d      = StReq;
            mem_req_d    = 1'b1;
            mem_we_d     = is_store;
            mem_addr_d   = addr;
            mem_wdata_d  = wdata_c;
            mem_be_d     = be_c;
            cnt_d        = '0;
            pend_rd_d    = rd;
            pend_instr_d = instr_in;
            pend_tag_d   = branch_in;
            pend_load_d  = is_load && !is_store;
            pend_size_d  = size;
            pend_sext_d  = sign_ext;
            pend_lane_d  = lane_c;
          end
        end
      end
      StReq: begin
        // Ack is checked first so an ack in the last allowed cycle beats the timeout.
        if (mem_ack || timeout_hit) begin
          state_d     = StIdle;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_rd_d    = pend_rd_q;
          out_instr_d = pend_instr_q;
          out_data_d  = '0;
          out_w_en_d  = 1'b0;
          if (mem_ack) begin
            if (pend_load_q) begin
              out_data_d = load_data_c;
              out_w_en_d = (pend_tag_q == bref_q);
            end
          end else begin
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bref_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      cnt_q        <= '0;
      pend_rd_q    <= '0;
      pend_instr_q <= '0;
      pend_tag_q   <= 1'b0;
      pend_load_q  <= 1'b0;
      pend_size_q  <= '0;
      pend_sext_q  <= 1'b0;
      pend_lane_q  <= '0;
      out_valid_q  <= 1'b0;
      out_rd_q     <= '0;
      out_data_q   <= '0;
      out_w_en_q   <= 1'b0;
      out_instr_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bref_q       <= bref_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      cnt_q        <= cnt_d;
      pend_rd_q    <= pend_rd_d;
      pend_instr_q <= pend_instr_d;
      pend_tag_q   <= pend_tag_d;
      pend_load_q  <= pend_load_d;
      pend_size_q  <= pend_size_d;
      pend_sext_q  <= pend_sext_d;
      pend_lane_q  <= pend_lane_d;
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      out_data_q   <= out_data_d;
      out_w_en_q   <= out_w_en_d;
      out_instr_q  <= out_instr_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign branch_ref_global = bref_q;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_be            = mem_be_q;
  assign out_valid         = out_valid_q;
  assign out_rd            = out_rd_q;
  assign out_data          = out_data_q;
  assign out_w_en          = out_w_en_q;
  assign out_instr         = out_instr_q;
  assign bus_err           = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (TIMEOUT=4): directed vector table, reset and branch
// sequences, then randomized transactions checked against a behavioural model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instr_in;
  logic        branch_in, branch_ref, branch_ref_global;
  logic        is_load, is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [3:0]  rd;
  logic [31:0] addr, wdata, alu_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid, out_ready;
  logic [3:0]  out_rd;
  logic [31:0] out_data;
  logic        out_w_en;
  logic [31:0] out_instr;
  logic        bus_err;

  int   total = 0;
  int   bad   = 0;
  logic cur_ref = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .branch_in(branch_in), .branch_ref(branch_ref),
    .branch_ref_global(branch_ref_global), .is_load(is_load), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .rd(rd), .addr(addr), .wdata(wdata),
    .alu_in(alu_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_w_en(out_w_en), .out_instr(out_instr), .bus_err(bus_err)
  );

  typedef struct {
    logic ld; logic st; logic [1:0] sz; logic sx; logic [3:0] rd;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] alu; logic [31:0] instr; logic br;
  } ins_t;

  typedef struct {
    bit tok; logic [31:0] data; logic wen; logic err; logic [3:0] be; logic [31:0] wd; int reqc;
  } obs_t;

  typedef struct {
    bit squash; bit bus; bit misal; bit tmo; bit tok; logic [3:0] be; logic [31:0] wd;
    logic [31:0] data; logic wen; logic err; int reqc;
  } exp_t;

  typedef struct {
    ins_t in; int delay; logic [31:0] rdata; bit flip;
    bit tok; logic [31:0] data; logic wen; logic err; logic [3:0] be; logic [31:0] wd; int reqc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model: byte count and lane offset drive everything arithmetically.
  function automatic exp_t model(input ins_t t, input int delay, input logic [31:0] rdata,
                                 input bit flip, input logic ref_acc);
    exp_t e;
    int nb, lane, tmp;
    logic [31:0] v, mask;
    bit nonmem;
    e = '{default: 0};
    nb = 4;
    lane = 0;
`ifdef MEM_ACCESS_BYTE_EN
    nb   = (t.sz == 2'b00) ? 1 : (t.sz == 2'b01) ? 2 : 4;
    lane = int'(t.addr[1:0]);
    e.misal = (lane % nb) != 0;
`endif
    tmp  = ((1 << nb) - 1) << lane;
    e.be = tmp[3:0];
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = t.wdata[8*(i % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v = (rdata >> (8 * lane)) & mask;
    if (t.sx && nb < 4 && ((v & ((mask >> 1) + 32'h1)) != 0)) v = v | ~mask;
    nonmem   = !t.ld && !t.st;
    e.squash = (t.br != ref_acc);
    e.tok    = !e.squash;
    e.bus    = !e.squash && !nonmem && !e.misal;
    e.tmo    = e.bus && (delay >= TO);
    e.reqc   = !e.bus ? 0 : (e.tmo ? TO : delay + 1);
    e.err    = !e.squash && !nonmem && (e.misal || e.tmo);
    if (nonmem) begin
      e.data = t.alu; e.wen = 1'b1;
    end else if (!e.bus || e.tmo || t.st) begin
      e.data = '0; e.wen = 1'b0;
    end else begin
      e.data = v; e.wen = !(flip && delay >= 1);
    end
    return e;
  endfunction

  task automatic drive_ins(input ins_t t);
    is_load = t.ld; is_store = t.st; size = t.sz; sign_ext = t.sx; rd = t.rd;
    addr = t.addr; wdata = t.wdata; alu_in = t.alu; instr_in = t.instr; branch_in = t.br;
  endtask

  // One instruction end to end; called at a negedge with the stage idle and empty.
  task automatic run_txn(input ins_t t, input int delay, input logic [31:0] rdata,
                         input bit flip, input int stall, input string nm, output obs_t o);
    exp_t e;
    int c;
    logic [31:0] held;
    o = '{default: 0};
    e = model(t, delay, rdata, flip, cur_ref);
    drive_ins(t);
    in_valid = 1'b1;
    #1;
    chk({nm, " in_ready idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (flip) begin cur_ref = !cur_ref; branch_ref = cur_ref; end
    #1;
    c = 0;
    while (!out_valid) begin
      if (!e.bus && c >= 2) break;
      if (c > 12) begin
        total++; bad++;
        $display("FAIL %s token wait: got none want token", nm);
        break;
      end
      if (mem_req) begin
        if (o.reqc == 0) begin o.be = mem_be; o.wd = mem_wdata; end
        o.reqc++;
        chk({nm, " mem_addr"}, mem_addr, t.addr);
        chk({nm, " mem_we"}, mem_we, t.st);
        chk({nm, " in_ready busy"}, in_ready, 0);
      end
      mem_ack   = e.bus && (c == delay);
      mem_rdata = (c == delay) ? rdata : $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      c++;
    end
    o.tok = out_valid;
    o.err = bus_err;
    chk({nm, " token"}, o.tok, e.tok);
    chk({nm, " req cycles"}, o.reqc, e.reqc);
    chk({nm, " bus_err"}, o.err, e.err);
    if (e.bus) begin
      chk({nm, " mem_be"}, o.be, e.be);
      chk({nm, " mem_wdata"}, o.wd, e.wd);
    end
    if (out_valid) begin
      o.data = out_data;
      o.wen  = out_w_en;
      held   = out_data;
      chk({nm, " out_data"}, o.data, e.data);
      chk({nm, " out_w_en"}, o.wen, e.wen);
      chk({nm, " out_rd"}, out_rd, t.rd);
      chk({nm, " out_instr"}, out_instr, t.instr);
      chk({nm, " mem_req low"}, mem_req, 0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk); #1;
        chk({nm, " hold valid"}, out_valid, 1);
        chk({nm, " hold data"}, out_data, held);
        chk({nm, " err pulse"}, bus_err, 0);
      end
      out_ready = 1'b1;
      #1;
      chk({nm, " in_ready drain"}, in_ready, 1);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk({nm, " drained"}, out_valid, 0);
    end
  endtask

  function automatic ins_t mk_ins(input logic ld, input logic st, input logic [1:0] sz,
                                  input logic sx, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] alu, input logic [3:0] r, input logic br);
    ins_t t;
    t.ld = ld; t.st = st; t.sz = sz; t.sx = sx; t.addr = a; t.wdata = wd; t.alu = alu;
    t.rd = r; t.br = br; t.instr = {8'hA5, a[11:0], alu[7:0], r};
    return t;
  endfunction

  function automatic vec_t mk_vec(input ins_t t, input int dly, input logic [31:0] rdat,
                                  input bit fl, input bit tok, input logic [31:0] dat,
                                  input logic wen, input logic err, input logic [3:0] be,
                                  input logic [31:0] wd, input int reqc);
    vec_t v;
    v.in = t; v.delay = dly; v.rdata = rdat; v.flip = fl; v.tok = tok; v.data = dat;
    v.wen = wen; v.err = err; v.be = be; v.wd = wd; v.reqc = reqc;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got stall want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    obs_t o;
    ins_t t;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    branch_ref = 1'b0;
    drive_ins(mk_ins(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_req", mem_req, 0);      chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_be", mem_be, 0);        chk("rst out_valid", out_valid, 0);
    chk("rst out_rd", out_rd, 0);        chk("rst out_data", out_data, 0);
    chk("rst out_w_en", out_w_en, 0);    chk("rst out_instr", out_instr, 0);
    chk("rst bus_err", bus_err, 0);      chk("rst bref", branch_ref_global, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Registered branch reference follows the controller one cycle later.
    branch_ref = 1'b1;
    #1;
    chk("bref not yet", branch_ref_global, 0);
    @(negedge clk); #1;
    chk("bref rise", branch_ref_global, 1);
    branch_ref = 1'b0;
    @(negedge clk); #1;
    chk("bref fall", branch_ref_global, 0);

    vecs.push_back(mk_vec(mk_ins(0, 0, 2, 0, 32'h0, 32'h0, 32'h1234, 4'd3, 0),
                          0, 0, 0, 1, 32'h1234, 1, 0, 0, 0, 0));
    vecs.push_back(mk_vec(mk_ins(1, 0, 2, 0, 32'h100, 32'h0, 32'h0, 4'd5, 0),
                          3, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 1, 0, 4'hF, 32'h0, 4));
    vecs.push_back(mk_vec(mk_ins(0, 1, 2, 0, 32'h200, 32'h1122_3344, 32'h0, 4'd6, 0),
                          0, 0, 0, 1, 32'h0, 0, 0, 4'hF, 32'h1122_3344, 1));
    vecs.push_back(mk_vec(mk_ins(1, 0, 2, 0, 32'h300, 32'h0, 32'h0, 4'd7, 0),
                          4, 32'h5555_5555, 0, 1, 32'h0, 0, 1, 4'hF, 32'h0, TO));
`ifdef MEM_ACCESS_BYTE_EN
    vecs.push_back(mk_vec(mk_ins(0, 1, 0, 0, 32'h103, 32'hAB, 32'h0, 4'd1, 0),
                          1, 0, 0, 1, 32'h0, 0, 0, 4'b1000, 32'hABAB_ABAB, 2));
    vecs.push_back(mk_vec(mk_ins(1, 0, 0, 1, 32'h102, 32'h0, 32'h0, 4'd2, 0),
                          0, 32'h0080_0000, 0, 1, 32'hFFFF_FF80, 1, 0, 4'b0100, 32'h0, 1));
    vecs.push_back(mk_vec(mk_ins(1, 0, 0, 0, 32'h102, 32'h0, 32'h0, 4'd2, 0),
                          0, 32'h0080_0000, 0, 1, 32'h0000_0080, 1, 0, 4'b0100, 32'h0, 1));
    vecs.push_back(mk_vec(mk_ins(1, 0, 1, 0, 32'h101, 32'h0, 32'h0, 4'd4, 0),
                          0, 0, 0, 1, 32'h0, 0, 1, 0, 0, 0));
    vecs.push_back(mk_vec(mk_ins(1, 0, 1, 1, 32'h102, 32'h0, 32'h0, 4'd8, 0),
                          2, 32'h8001_0000, 0, 1, 32'hFFFF_8001, 1, 0, 4'b1100, 32'h0, 3));
    vecs.push_back(mk_vec(mk_ins(1, 0, 2, 0, 32'h102, 32'h0, 32'h0, 4'd9, 0),
                          0, 0, 0, 1, 32'h0, 0, 1, 0, 0, 0));
    vecs.push_back(mk_vec(mk_ins(0, 1, 1, 0, 32'h102, 32'h1234, 32'h0, 4'd10, 0),
                          0, 0, 0, 1, 32'h0, 0, 0, 4'b1100, 32'h1234_1234, 1));
`else
    vecs.push_back(mk_vec(mk_ins(0, 1, 0, 0, 32'h103, 32'hAB, 32'h0, 4'd1, 0),
                          1, 0, 0, 1, 32'h0, 0, 0, 4'hF, 32'h0000_00AB, 2));
    vecs.push_back(mk_vec(mk_ins(1, 0, 1, 1, 32'h101, 32'h0, 32'h0, 4'd4, 0),
                          0, 32'h8081_8283, 0, 1, 32'h8081_8283, 1, 0, 4'hF, 32'h0, 1));
`endif
    // Wrong-path load is dropped; then a load whose branch flips while in flight.
    vecs.push_back(mk_vec(mk_ins(1, 0, 2, 0, 32'h400, 32'h0, 32'h0, 4'd11, 1),
                          0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mk_vec(mk_ins(1, 0, 2, 0, 32'h104, 32'h0, 32'h0, 4'd12, 0),
                          2, 32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 0, 0, 4'hF, 32'h0, 3));

    foreach (vecs[i]) begin
      run_txn(vecs[i].in, vecs[i].delay, vecs[i].rdata, vecs[i].flip, i % 2,
              $sformatf("vec%0d", i), o);
      chk($sformatf("vec%0d tbl token", i), o.tok, vecs[i].tok);
      chk($sformatf("vec%0d tbl reqc", i), o.reqc, vecs[i].reqc);
      chk($sformatf("vec%0d tbl err", i), o.err, vecs[i].err);
      if (vecs[i].tok) begin
        chk($sformatf("vec%0d tbl data", i), o.data, vecs[i].data);
        chk($sformatf("vec%0d tbl wen", i), o.wen, vecs[i].wen);
      end
      if (vecs[i].reqc > 0) begin
        chk($sformatf("vec%0d tbl be", i), o.be, vecs[i].be);
        chk($sformatf("vec%0d tbl wd", i), o.wd, vecs[i].wd);
      end
    end

    // Reset while a load is waiting for its ack.
    t = mk_ins(1, 0, 2, 0, 32'h500, 32'h0, 32'h0, 4'd13, cur_ref);
    drive_ins(t);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("midrst req before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst mem_req", mem_req, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst quiet", mem_req, 0);

    // Reset while a token is waiting on write-back.
    t = mk_ins(0, 0, 2, 0, 32'h0, 32'h0, 32'h77, 4'd14, cur_ref);
    drive_ins(t);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("tokrst pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("tokrst cleared", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      t.ld = (kind == 1);
      t.st = (kind == 2);
      t.sz = 2'($urandom_range(0, 3));
      t.sx = 1'($urandom_range(0, 1));
      t.rd = 4'($urandom_range(0, 15));
      t.addr = $urandom; t.wdata = $urandom; t.alu = $urandom; t.instr = $urandom;
      t.br = ($urandom_range(0, 7) == 0) ? !cur_ref : cur_ref;
      run_txn(t, int'($urandom_range(0, 5)), $urandom, ($urandom_range(0, 4) == 0),
              int'($urandom_range(0, 2)), $sformatf("rnd%0d", n), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
